signal_demodulator: RTL and testbench
=====================================

Name: signal_demodulator

Overview:
- Receive-side counterpart of the BPSK transmitter: recovers one bit per carrier period from a stream of ADC samples.
- Each symbol's samples are correlated against the in-phase reference sine. A negative correlation decodes as 1 (carrier shifted half a period); a zero or positive correlation decodes as 0.
- Sits between the ADC capture logic and the receive bit/framing logic.
- Symbol boundaries come from an external sync strobe, supplied by preamble detection upstream.

Parameters:
- DATA_WIDTH, 8: sample width. Offset-binary, midscale = 2^(DATA_WIDTH-1). Same encoding as the DAC codes.
- WAVELENGTH, 15: last phase index of a symbol. A symbol spans WAVELENGTH+1 samples, matching the transmitter's period.
- SINE_RESOLUTION, 16: depth of the shared sine table. Phase index width is $clog2(SINE_RESOLUTION)+1.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(WAVELENGTH+1)+1: width of the signed correlation accumulator. It cannot overflow.

Ports:
- clk  in  1  sample clock, one sample per cycle when valid
- rst_n  in  1  asynchronous active-low reset
- sample_in  in  DATA_WIDTH  ADC sample, offset binary
- sample_valid  in  1  qualifies sample_in; invalid cycles are ignored entirely
- symbol_start  in  1  with sample_valid, marks sample_in as phase index 0 of a new symbol
- bit_out  out  1  decoded bit, held until the next bit_valid
- bit_valid  out  1  one-cycle pulse per decoded symbol
- correlation  out  ACC_WIDTH  signed final sum of the decoded symbol, updated with bit_valid
- locked  out  1  high once the first symbol_start has been accepted

Behaviour:
- Reset (async, rst_n low):
  - bit_out=0, bit_valid=0, correlation=0, locked=0.
  - Phase index=0; accumulator=0; all pipeline valid flags cleared.
  - A reset mid-symbol discards the partial symbol and produces no bit_valid.
- Sample conversion: signed sample = sample_in with MSB inverted, i.e. sample_in − midscale.
- Reference: phase index drives wave_table_sine (registered, 1-cycle latency). Its output is also offset binary and is converted the same way.
- Pipeline, one accepted sample per cycle:
  - S0 capture: sample, index, first/last flags.
  - S1: table output aligned with the delayed sample.
  - S2: signed product registered.
  - S3: accumulate.
- Phase index:
  - Advances only on sample_valid.
  - Wraps from WAVELENGTH to 0. That sample is flagged last, and the next sample is implicitly index 0 of the next symbol.
  - symbol_start with sample_valid forces index 0 for that sample, regardless of the current count.
- Before locked: samples flow through the pipeline, but no bit_valid is ever produced.
  - locked sets on the first accepted symbol_start and stays set until reset.
- Accumulation:
  - A product tagged first loads the accumulator; other products add to it.
  - A product tagged last completes the sum. On the following edge: correlation = final sum, bit_out = sign bit of the sum (1 if negative), bit_valid = 1.
- Latency: bit_valid is high exactly 3 cycles after the edge that accepted the symbol's last sample. This assumes sample_valid stays high; gaps stall the count, not the pipeline.
- Resync mid-symbol: symbol_start while index≠0 abandons the partial symbol.
  - No bit_valid for it.
  - The accumulator reloads with the new first product.
- symbol_start on a sample that would also be a natural wrap (index=WAVELENGTH): symbol_start wins. The sample is index 0 and the previous symbol is abandoned.
- Zero sum decodes as 0.
- Back-to-back symbols with continuous sample_valid give one bit_valid every WAVELENGTH+1 cycles with no dead cycles.

Decomposition:
- Shared package (parameters.svh): DATA_WIDTH, WAVELENGTH, SINE_RESOLUTION, SHIFT, and derived ACC_WIDTH and phase-index width.
  - These are shared with the transmitter so both ends agree on the carrier.
- Reuse wave_table_sine unchanged.
- One new sub-module, symbol_correlator: signed multiply, first/last-tagged accumulate, and result/sign register. It is separately testable.

Test Plan:
- Reset release, then the transmitter sine for bit 0 with symbol_start on the first sample (DATA_WIDTH=8, WAVELENGTH=15) -> locked=1; bit_valid 3 cycles after the 16th sample; bit_out=0; correlation>0.
- Five back-to-back symbols 1,0,1,1,0 with continuous valid -> five bit_valid pulses spaced exactly 16 cycles; bit_out=1,0,1,1,0; correlation sign alternates accordingly.
- Stream a full symbol before any symbol_start -> no bit_valid and locked=0. Then sync plus symbol 1 -> single bit_valid, bit_out=1.
- sample_valid deasserted for 4 cycles mid-symbol -> decoded bit unchanged; bit_valid delayed by exactly 4 cycles.
- symbol_start asserted at index 7 of a symbol -> partial symbol yields no bit_valid; next bit_valid occurs 16 samples + 3 cycles after the resync.
- Constant midscale input (0x80) -> correlation=0, bit_out=0. Then assert rst_n low mid-symbol -> all outputs 0 asynchronously and locked=0.

Source files
------------

// File: rtl/signal_demodulator_pkg.sv
// signal_demodulator_pkg
//   Carrier parameters shared by the BPSK transmitter and this demodulator,
//   plus the pipeline tag type and the offset-binary to signed helper.
package signal_demodulator_pkg;

  localparam int unsigned DATA_WIDTH      = 8;
  localparam int unsigned WAVELENGTH      = 15;
  localparam int unsigned SINE_RESOLUTION = 16;
  localparam int unsigned SHIFT           = $clog2(SINE_RESOLUTION);
  localparam int unsigned PHASE_WIDTH     = $clog2(SINE_RESOLUTION) + 1;
  localparam int unsigned PROD_WIDTH      = 2 * DATA_WIDTH;
  localparam int unsigned ACC_WIDTH       = 2 * DATA_WIDTH + $clog2(WAVELENGTH + 1) + 1;

  // Travels alongside each sample through the pipeline.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  // Offset binary to two's complement: invert the MSB (x - midscale).
  function automatic logic signed [DATA_WIDTH-1:0] to_signed(input logic [DATA_WIDTH-1:0] x);
    return {~x[DATA_WIDTH-1], x[DATA_WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/signal_demodulator_correlator.sv
// symbol_correlator
//   Multiplies each sample by its reference, accumulates over a symbol
//   (first-tagged product reloads, last-tagged product completes) and
//   registers the final sum and its sign as the decoded bit.
//   clk_i, rst_n_i : clock, async active-low reset
//   sample_i       : offset-binary sample aligned with ref_i
//   ref_i          : offset-binary reference sine
//   tag_i          : valid/first/last tag for this sample
//   bit_o          : sign of last completed sum (1 = negative)
//   bit_valid_o    : one-cycle pulse per completed symbol
//   correlation_o  : last completed signed sum
module symbol_correlator
  import signal_demodulator_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [DATA_WIDTH-1:0]       sample_i,
  input  logic [DATA_WIDTH-1:0]       ref_i,
  input  tag_t                        tag_i,
  output logic                        bit_o,
  output logic                        bit_valid_o,
  output logic signed [ACC_WIDTH-1:0] correlation_o
);

  logic signed [DATA_WIDTH-1:0] sample_s;
  logic signed [DATA_WIDTH-1:0] ref_s;
  logic signed [PROD_WIDTH-1:0] prod_d;
  logic signed [PROD_WIDTH-1:0] prod_q;
  tag_t                         prod_tag_q;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  corr_q;
  logic                         bit_q;
  logic                         bit_valid_q;

  always_comb begin
    sample_s = to_signed(sample_i);
    ref_s    = to_signed(ref_i);
    prod_d   = sample_s * ref_s;
    prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_q[PROD_WIDTH-1]}}, prod_q};
    acc_d    = prod_tag_q.first ? prod_ext : acc_q + prod_ext;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prod_q      <= '0;
      prod_tag_q  <= '0;
      acc_q       <= '0;
      corr_q      <= '0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      prod_tag_q  <= tag_i;
      bit_valid_q <= prod_tag_q.valid & prod_tag_q.last;
      if (prod_tag_q.valid) acc_q <= acc_d;
      // The result register takes the same sum the accumulator is loading,
      // so the bit appears on the accumulate edge with no extra stage.
      if (prod_tag_q.valid && prod_tag_q.last) begin
        corr_q <= acc_d;
        bit_q  <= acc_d[ACC_WIDTH-1];
      end
    end
  end

  assign bit_o         = bit_q;
  assign bit_valid_o   = bit_valid_q;
  assign correlation_o = corr_q;

endmodule

// File: rtl/wave_table_sine.sv
// wave_table_sine
//   Registered sine lookup shared with the transmitter (1-cycle latency).
//   Output is offset binary, amplitude 127 around midscale 128.
//   clk_i   : clock
//   phase_i : phase index, 0..SINE_RESOLUTION-1
//   sine_o  : sine code for the phase presented on the previous edge
module wave_table_sine
  import signal_demodulator_pkg::*;
(
  input  logic                   clk_i,
  input  logic [PHASE_WIDTH-1:0] phase_i,
  output logic [DATA_WIDTH-1:0]  sine_o
);

  localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [DATA_WIDTH-1:0] TABLE [SINE_RESOLUTION] = '{
    8'd128, 8'd177, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd177,
    8'd128, 8'd79,  8'd38,  8'd11,  8'd1,   8'd11,  8'd38,  8'd79
  };

  logic [DATA_WIDTH-1:0] sine_q;

  // Out-of-range phases (never produced by the demodulator) read as midscale.
  always_ff @(posedge clk_i) begin
    if (phase_i < PHASE_WIDTH'(SINE_RESOLUTION)) sine_q <= TABLE[phase_i[SHIFT-1:0]];
    else                                         sine_q <= MID;
  end

  assign sine_o = sine_q;

endmodule

// File: rtl/signal_demodulator.sv
// signal_demodulator
//   BPSK receive path: correlates each symbol of ADC samples against the
//   in-phase reference sine and decodes the sign as one bit.
//   clk          : sample clock
//   rst_n        : async active-low reset
//   sample_in    : offset-binary ADC sample
//   sample_valid : qualifies sample_in
//   symbol_start : with sample_valid, sample_in is phase 0 of a new symbol
//   bit_out      : decoded bit, held until the next bit_valid
//   bit_valid    : one-cycle pulse per decoded symbol
//   correlation  : signed final sum of the decoded symbol
//   locked       : set by the first accepted symbol_start
module signal_demodulator
  import signal_demodulator_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       sample_in,
  input  logic                        sample_valid,
  input  logic                        symbol_start,
  output logic                        bit_out,
  output logic                        bit_valid,
  output logic signed [ACC_WIDTH-1:0] correlation,
  output logic                        locked
);

  localparam logic [PHASE_WIDTH-1:0] LAST_IDX = PHASE_WIDTH'(WAVELENGTH);

  logic [PHASE_WIDTH-1:0] count_q, count_d;
  logic [PHASE_WIDTH-1:0] idx_cur;
  logic                   wrap;
  logic                   locked_q, locked_d;
  tag_t                   tag_d;

  logic [DATA_WIDTH-1:0]  s0_sample_q;
  logic [PHASE_WIDTH-1:0] s0_idx_q;
  tag_t                   s0_tag_q;
  logic [DATA_WIDTH-1:0]  s1_sample_q;
  tag_t                   s1_tag_q;
  logic [DATA_WIDTH-1:0]  ref_code;

  always_comb begin
    idx_cur  = symbol_start ? '0 : count_q;
    wrap     = (idx_cur == LAST_IDX);
    count_d  = count_q;
    locked_d = locked_q;
    tag_d    = '0;
    if (sample_valid) begin
      count_d = wrap ? '0 : idx_cur + 1'b1;
      if (symbol_start) locked_d = 1'b1;
      tag_d.valid = 1'b1;
      tag_d.first = (idx_cur == '0);
      // Only symbols that began after lock may complete; a symbol_start
      // forces index 0, so it can never also be tagged last.
      tag_d.last  = wrap & locked_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      locked_q    <= 1'b0;
      s0_sample_q <= '0;
      s0_idx_q    <= '0;
      s0_tag_q    <= '0;
      s1_sample_q <= '0;
      s1_tag_q    <= '0;
    end else begin
      count_q     <= count_d;
      locked_q    <= locked_d;
      s0_sample_q <= sample_in;
      s0_idx_q    <= idx_cur;
      s0_tag_q    <= tag_d;
      s1_sample_q <= s0_sample_q;
      s1_tag_q    <= s0_tag_q;
    end
  end

  wave_table_sine u_sine (
    .clk_i   (clk),
    .phase_i (s0_idx_q),
    .sine_o  (ref_code)
  );

  symbol_correlator u_corr (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .sample_i      (s1_sample_q),
    .ref_i         (ref_code),
    .tag_i         (s1_tag_q),
    .bit_o         (bit_out),
    .bit_valid_o   (bit_valid),
    .correlation_o (correlation)
  );

  assign locked = locked_q;

endmodule

// File: tb/tb_signal_demodulator.sv
module tb_signal_demodulator;
  import signal_demodulator_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [DATA_WIDTH-1:0]       sample_in = '0;
  logic                        sample_valid = 1'b0;
  logic                        symbol_start = 1'b0;
  logic                        bit_out;
  logic                        bit_valid;
  logic signed [ACC_WIDTH-1:0] correlation;
  logic                        locked;

  signal_demodulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .symbol_start (symbol_start),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .correlation  (correlation),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter carrier codes, amplitude 127 around 128.
  int SIN [16] = '{128, 177, 218, 245, 255, 245, 218, 177,
                   128,  79,  38,  11,   1,  11,  38,  79};

  // Hand-computed sums: 4*(49^2+90^2+117^2) + 2*127^2 = 129018.
  localparam int CORR_BIT0 = 129018;
  localparam int CORR_BIT1 = -129018;

  typedef struct {
    int b;
    int corr;
    int at;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every bit_valid must match the oldest expected symbol.
  always @(negedge clk) begin
    if (rst_n && bit_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_bit_valid: got pulse expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bit_out", int'(bit_out), e.b);
        check("correlation", int'(correlation), e.corr);
        check("bit_valid_cycle", cyc, e.at);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      symbol_start = 1'b0;
      sample_in    = 8'hFF;
    end
  endtask

  // mode: 0 = bit 0, 1 = bit 1, 2 = constant midscale.
  // Pushes an expectation on the 16th sample when expect_out is set.
  task automatic send_symbol(input int mode, input bit sync, input bit expect_out,
                             input int n, input int gap_after, input int gap_len);
    int code;
    for (int k = 0; k < n; k++) begin
      if (k == gap_after && gap_len > 0) idle(gap_len);
      code = (mode == 2) ? 128 : (mode == 1) ? SIN[(k + 8) % 16] : SIN[k];
      @(negedge clk);
      sample_in    = code[7:0];
      sample_valid = 1'b1;
      symbol_start = sync && (k == 0);
      if (expect_out && k == 15)
        sb.push_back('{(mode == 1) ? 1 : 0,
                       (mode == 0) ? CORR_BIT0 : (mode == 1) ? CORR_BIT1 : 0,
                       cyc + 4});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_bit_out", int'(bit_out), 0);
    check("reset_bit_valid", int'(bit_valid), 0);
    check("reset_correlation", int'(correlation), 0);
    check("reset_locked", int'(locked), 0);
    rst_n = 1'b1;

    // Full symbol before any sync: no output, still unlocked.
    send_symbol(1, 1'b0, 1'b0, 16, -1, 0);
    @(negedge clk);
    sample_valid = 1'b0;
    check("prelock_locked", int'(locked), 0);

    // Sync + symbol 1, then bit 0 and five back-to-back symbols.
    send_symbol(1, 1'b1, 1'b1, 16, -1, 0);
    check("locked_after_sync", int'(locked), 1);
    send_symbol(0, 1'b0, 1'b1, 16, -1, 0);
    send_symbol(1, 1'b0, 1'b1, 16, -1, 0);
    send_symbol(0, 1'b0, 1'b1, 16, -1, 0);
    send_symbol(1, 1'b0, 1'b1, 16, -1, 0);
    send_symbol(1, 1'b0, 1'b1, 16, -1, 0);
    send_symbol(0, 1'b0, 1'b1, 16, -1, 0);

    // Four invalid cycles mid-symbol stall the phase count.
    send_symbol(0, 1'b0, 1'b1, 16, 8, 4);

    // Resync at index 7 abandons a partial opposite-polarity symbol.
    send_symbol(0, 1'b0, 1'b0, 7, -1, 0);
    send_symbol(1, 1'b1, 1'b1, 16, -1, 0);

    // Sync on the sample that would be a natural wrap (index 15).
    send_symbol(1, 1'b0, 1'b0, 15, -1, 0);
    send_symbol(0, 1'b1, 1'b1, 16, -1, 0);

    // Constant midscale decodes as zero sum, bit 0.
    send_symbol(1, 1'b0, 1'b1, 16, -1, 0);
    send_symbol(2, 1'b1, 1'b1, 16, -1, 0);

    // Symbol 1, then reset in the middle of the next symbol.
    send_symbol(1, 1'b0, 1'b1, 16, -1, 0);
    send_symbol(0, 1'b0, 1'b0, 8, -1, 0);
    check("locked_before_reset", int'(locked), 1);
    check("bit_out_before_reset", int'(bit_out), 1);
    #2;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("async_reset_bit_out", int'(bit_out), 0);
    check("async_reset_bit_valid", int'(bit_valid), 0);
    check("async_reset_correlation", int'(correlation), 0);
    check("async_reset_locked", int'(locked), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    check("pending_expectations", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
